// File: rtl/irq_ctrl.sv
// ============================================================================
//  Module      : irq_ctrl
//  Description : Memory-mapped three-source interrupt controller with edge
//                detection, masking, fixed/round-robin arbitration and an
//                external-source acknowledge pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_ctrl #(
  parameter logic [31:0] BASE = 32'h0000_7f20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteen,
  output logic [31:0] rdata,
  input  logic [2:0]  irq_src,
  output logic [2:0]  hw_int,
  output logic        irq_any,
  output logic [31:0] m_int_addr,
  output logic [3:0]  m_int_byteen
);

  localparam logic [1:0] c_REG_CTRL  = 2'd0;
  localparam logic [1:0] c_REG_MASK  = 2'd1;
  localparam logic [1:0] c_REG_PEND  = 2'd2;
  localparam logic [1:0] c_REG_CLAIM = 2'd3;

  logic       r_en;
  logic       r_rr;
  logic [2:0] r_mask;
  logic [2:0] r_pend;
  logic [2:0] r_prev;
  logic [1:0] r_last;
  logic       r_ack;

  logic       w_in_win;
  logic       w_wr;
  logic       w_wr_ctrl;
  logic       w_wr_mask;
  logic       w_wr_pend;
  logic       w_wr_claim;
  logic       w_cmp_ok;
  logic [2:0] w_cmp_vec;
  logic [2:0] w_clr;
  logic [2:0] w_evt;
  logic [2:0] w_cand;
  logic       w_valid;
  logic [1:0] w_start;
  logic [1:0] w_id;
  logic       w_unused;

  assign w_in_win   = (addr[31:4] == BASE[31:4]);
  assign w_wr       = w_in_win && (byteen != 4'd0);
  assign w_wr_ctrl  = w_wr && (addr[3:2] == c_REG_CTRL);
  assign w_wr_mask  = w_wr && (addr[3:2] == c_REG_MASK);
  assign w_wr_pend  = w_wr && (addr[3:2] == c_REG_PEND);
  assign w_wr_claim = w_wr && (addr[3:2] == c_REG_CLAIM);

  // id 3 shifts out of the 3-bit vector, so an invalid completion clears nothing
  assign w_cmp_ok  = w_wr_claim && (wdata[1:0] != 2'd3);
  assign w_cmp_vec = 3'b001 << wdata[1:0];

  assign w_clr = (w_wr_pend ? wdata[2:0] : 3'b000) |
                 (w_cmp_ok  ? w_cmp_vec  : 3'b000);
  assign w_evt = irq_src & ~r_prev;

  assign w_cand  = r_pend & r_mask;
  assign w_valid = |w_cand;
  assign w_start = (r_last >= 2'd2) ? 2'd0 : r_last + 2'd1;

  always_comb begin
    w_id = 2'd0;
    if (!r_rr || (w_start == 2'd0)) begin
      if (w_cand[0])      w_id = 2'd0;
      else if (w_cand[1]) w_id = 2'd1;
      else if (w_cand[2]) w_id = 2'd2;
    end else if (w_start == 2'd1) begin
      if (w_cand[1])      w_id = 2'd1;
      else if (w_cand[2]) w_id = 2'd2;
      else if (w_cand[0]) w_id = 2'd0;
    end else begin
      if (w_cand[2])      w_id = 2'd2;
      else if (w_cand[0]) w_id = 2'd0;
      else if (w_cand[1]) w_id = 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en   <= 1'b0;
      r_rr   <= 1'b0;
      r_mask <= 3'b000;
      r_pend <= 3'b000;
      r_prev <= 3'b000;
      r_last <= 2'd2;
      r_ack  <= 1'b0;
    end else begin
      r_prev <= irq_src;
      // new edges win over a same-cycle clear
      r_pend <= (r_pend & ~w_clr) | w_evt;
      r_ack  <= w_wr_claim && (wdata[1:0] == 2'd2);
      if (w_wr_ctrl) begin
        r_en <= wdata[0];
        r_rr <= wdata[1];
      end
      if (w_wr_mask) r_mask <= wdata[2:0];
      if (w_cmp_ok)  r_last <= wdata[1:0];
    end
  end

  always_comb begin
    rdata = 32'd0;
    if (w_in_win) begin
      case (addr[3:2])
        c_REG_CTRL:  rdata = {30'd0, r_rr, r_en};
        c_REG_MASK:  rdata = {29'd0, r_mask};
        c_REG_PEND:  rdata = {29'd0, r_pend};
        default:     rdata = {w_valid, 29'd0, w_id};
      endcase
    end
  end

  assign hw_int       = r_pend & r_mask & {3{r_en}};
  assign irq_any      = |hw_int;
  assign m_int_addr   = r_ack ? 32'h0000_7f20 : 32'd0;
  assign m_int_byteen = r_ack ? 4'b0001 : 4'b0000;

  assign w_unused = &{1'b0, addr[1:0], wdata[31:3]};

endmodule

`default_nettype wire

// File: tb/tb_irq_ctrl.sv
// ============================================================================
//  Module      : tb_irq_ctrl
//  Description : Directed self-checking bench for irq_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_irq_ctrl;

  localparam logic [31:0] c_BASE = 32'h0000_7f20;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  byteen;
  logic [31:0] rdata;
  logic [2:0]  irq_src;
  logic [2:0]  hw_int;
  logic        irq_any;
  logic [31:0] m_int_addr;
  logic [3:0]  m_int_byteen;

  int total = 0;
  int bad   = 0;

  irq_ctrl #(.BASE(c_BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .wdata        (wdata),
    .byteen       (byteen),
    .rdata        (rdata),
    .irq_src      (irq_src),
    .hw_int       (hw_int),
    .irq_any      (irq_any),
    .m_int_addr   (m_int_addr),
    .m_int_byteen (m_int_byteen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] r, input logic [31:0] d);
    addr   = c_BASE | {26'd0, r, 2'b00};
    wdata  = d;
    byteen = 4'hF;
    tick();
    byteen = 4'h0;
  endtask

  task automatic rd(input string tag, input logic [1:0] r, input logic [31:0] exp);
    addr = c_BASE | {26'd0, r, 2'b00};
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    reset = 1'b1; addr = 32'd0; wdata = 32'd0; byteen = 4'd0; irq_src = 3'b000;
    tick(); tick();
    reset = 1'b0;

    // reset state
    chk("rst_hw_int", {29'd0, hw_int}, 32'd0);
    chk("rst_irq_any", {31'd0, irq_any}, 32'd0);
    chk("rst_ack_addr", m_int_addr, 32'd0);
    chk("rst_ack_be", {28'd0, m_int_byteen}, 32'd0);
    rd("rst_ctrl", 2'd0, 32'd0);
    rd("rst_mask", 2'd1, 32'd0);
    rd("rst_pend", 2'd2, 32'd0);
    rd("rst_claim", 2'd3, 32'd0);

    // masked pend, then enable
    irq_src = 3'b001; tick();
    rd("t1_pend", 2'd2, 32'd1);
    chk("t1_hw_masked", {29'd0, hw_int}, 32'd0);
    wr(2'd1, 32'd7);
    chk("t1_hw_en0", {29'd0, hw_int}, 32'd0);
    wr(2'd0, 32'd1);
    chk("t1_hw_int", {29'd0, hw_int}, 32'd1);
    chk("t1_irq_any", {31'd0, irq_any}, 32'd1);
    addr = 32'h0000_7f38; #1;
    chk("t1_outside", rdata, 32'd0);
    wr(2'd2, 32'd1);
    rd("t1_w1c", 2'd2, 32'd0);
    irq_src = 3'b000; tick();

    // fixed priority and ack pulse
    irq_src = 3'b101; tick();
    rd("t2_claim0", 2'd3, 32'h8000_0000);
    wr(2'd3, 32'd0);
    chk("t2_no_ack", {28'd0, m_int_byteen}, 32'd0);
    rd("t2_claim2", 2'd3, 32'h8000_0002);
    wr(2'd3, 32'd2);
    chk("t2_ack_addr", m_int_addr, 32'h0000_7f20);
    chk("t2_ack_be", {28'd0, m_int_byteen}, 32'd1);
    tick();
    chk("t2_ack_end", {28'd0, m_int_byteen}, 32'd0);
    rd("t2_pend", 2'd2, 32'd0);
    irq_src = 3'b000; tick();

    // round-robin
    wr(2'd0, 32'd3);
    irq_src = 3'b111; tick();
    for (int i = 0; i < 3; i++) begin
      rd($sformatf("t3_rr_a%0d", i), 2'd3, 32'h8000_0000 | i);
      wr(2'd3, i);
    end
    irq_src = 3'b000; tick();
    irq_src = 3'b111; tick();
    for (int i = 0; i < 3; i++) begin
      rd($sformatf("t3_rr_b%0d", i), 2'd3, 32'h8000_0000 | i);
      wr(2'd3, i);
    end
    irq_src = 3'b000; tick();
    irq_src = 3'b111; tick();
    wr(2'd3, 32'd1);
    irq_src = 3'b101; tick();
    irq_src = 3'b111; tick();
    rd("t3_rr_after1", 2'd3, 32'h8000_0002);
    wr(2'd2, 32'd7);
    irq_src = 3'b000; tick();

    // held level is one event
    irq_src = 3'b010;
    for (int i = 0; i < 10; i++) tick();
    rd("t4_pend_held", 2'd2, 32'd2);
    wr(2'd2, 32'd2);
    tick(); tick();
    rd("t4_stay_clear", 2'd2, 32'd0);
    irq_src = 3'b000; tick();
    irq_src = 3'b010; tick();
    rd("t4_new_edge", 2'd2, 32'd2);
    wr(2'd2, 32'd2);
    irq_src = 3'b000; tick();

    // W1C colliding with new edge
    irq_src = 3'b001;
    wr(2'd2, 32'd1);
    rd("t5_collide", 2'd2, 32'd1);

    // reset truncates ack
    irq_src = 3'b101; tick();
    reset = 1'b1;
    wr(2'd3, 32'd2);
    reset = 1'b0;
    chk("t6_ack_be", {28'd0, m_int_byteen}, 32'd0);
    chk("t6_ack_addr", m_int_addr, 32'd0);
    chk("t6_hw_int", {29'd0, hw_int}, 32'd0);
    rd("t6_ctrl", 2'd0, 32'd0);
    rd("t6_mask", 2'd1, 32'd0);
    rd("t6_pend", 2'd2, 32'd0);
    tick();
    rd("t6_pend_relearn", 2'd2, 32'd5);
    wr(2'd1, 32'd7);
    rd("t6_claim_noen", 2'd3, 32'h8000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
